// File: rtl/psdi_fir_pkg.sv
// Shared types and sizing helpers for the time-multiplexed multi-channel FIR.
// FSM encoding, width derivation and saturation limits.
package psdi_fir_pkg;

    typedef enum logic [2:0] {IDLE, MAC, DRAIN, STORE, OUT} fir_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

    // Accumulator never overflows: full product width plus one bit per tap doubling.
    function automatic int acc_width(input int dw, input int cw, input int ntaps);
        return dw + cw + clog2(ntaps);
    endfunction

    function automatic longint sat_hi(input int dw);
        return (longint'(1) << (dw - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int dw);
        return -(longint'(1) << (dw - 1));
    endfunction

endpackage

// File: rtl/psdi_fir_mac.sv
// Shared multiply-accumulate with round-half-up output scaling.
// PSDI_FIR_SAT_EN: clamp the scaled result to the DW range instead of wrapping.
module psdi_fir_mac
    import psdi_fir_pkg::*;
#(
    parameter int DW   = 18,
    parameter int CW   = 8,
    parameter int ACCW = 30
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clr,
    input  logic                 i_en,
    input  logic signed [CW-1:0] i_coef,
    input  logic signed [DW-1:0] i_x,
    input  logic        [4:0]    i_nquant,
    output logic signed [DW-1:0] o_y
);
    typedef logic signed [ACCW:0] wide_t;

    logic signed [ACCW-1:0]  r_acc;
    logic signed [DW+CW-1:0] w_prod;
    logic        [4:0]       w_sh_amt;
    wide_t                   w_rnd;
`ifdef PSDI_FIR_SAT_EN
    localparam wide_t SAT_HI = wide_t'(sat_hi(DW));
    localparam wide_t SAT_LO = wide_t'(sat_lo(DW));
    wide_t                   w_sh;
`endif

    assign w_prod = i_coef * i_x;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)   r_acc <= '0;
        else if (i_clr) r_acc <= '0;
        else if (i_en)  r_acc <= r_acc + ACCW'(w_prod);
    end

    // One extra bit of headroom so the rounding offset cannot wrap.
    always_comb begin
        w_sh_amt = (int'(i_nquant) > ACCW - 1) ? 5'(ACCW - 1) : i_nquant;
        w_rnd    = wide_t'(r_acc);
        if (w_sh_amt != 5'd0) w_rnd = w_rnd + (wide_t'(1) <<< (w_sh_amt - 5'd1));
`ifdef PSDI_FIR_SAT_EN
        w_sh = w_rnd >>> w_sh_amt;
        if (w_sh > SAT_HI)      o_y = SAT_HI[DW-1:0];
        else if (w_sh < SAT_LO) o_y = SAT_LO[DW-1:0];
        else                    o_y = w_sh[DW-1:0];
`else
        o_y = DW'(w_rnd >>> w_sh_amt);
`endif
    end

endmodule

// File: rtl/psdi_fir_mc.sv
// Multi-channel FIR: one shared MAC walks every channel's delay line per frame.
// Output clamping is selected with PSDI_FIR_SAT_EN (inside psdi_fir_mac).
module psdi_fir_mc
    import psdi_fir_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int DW    = 18,
    parameter int CW    = 8,
    parameter int NTAPS = 16,
    parameter int AW    = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 data_en,
    input  logic [3:0]           Nfreq,
    input  logic [4:0]           Nquant,
    input  logic                 bypass,
    output logic [AW-1:0]        RAM_coefs_addr,
    input  logic signed [CW-1:0] RAM_coefs_dataout,
    input  logic [NCH*DW-1:0]    data_in,
    output logic [NCH*DW-1:0]    data_out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 overrun
);
    localparam int LW   = clog2(NTAPS);
    localparam int CHW  = (NCH > 1) ? clog2(NCH) : 1;
    localparam int ACCW = acc_width(DW, CW, NTAPS);

    fir_state_t           r_state;
    logic [LW-1:0]        r_wp, r_tap;
    logic [CHW-1:0]       r_ch;
    logic [4:0]           r_nquant;
    logic [AW-1:0]        r_addr, r_base;
    logic signed [DW-1:0] r_dl [NCH][NTAPS];
    logic signed [DW-1:0] r_x;
    logic                 r_mac_vld;
    logic [NCH*DW-1:0]    r_res, r_data_out;
    logic                 r_out_valid, r_busy, r_overrun;

    logic                 w_accept;
    logic [LW-1:0]        w_rd;
    logic [AW-1:0]        w_base;
    logic signed [DW-1:0] w_y;
    logic [NCH*DW-1:0]    w_res;

    assign w_accept = data_en && (r_state == IDLE || r_state == OUT);
    assign w_rd     = r_wp - r_tap;
    assign w_base   = AW'(int'(Nfreq) * NTAPS);

    assign RAM_coefs_addr = r_addr;
    assign data_out       = r_data_out;
    assign out_valid      = r_out_valid;
    assign busy           = r_busy;
    assign overrun        = r_overrun;

    always_comb begin
        w_res = r_res;
        w_res[r_ch*DW +: DW] = w_y;
    end

    psdi_fir_mac #(.DW(DW), .CW(CW), .ACCW(ACCW)) u_mac (
        .i_clk    (clock),
        .i_rst_n  (reset),
        .i_clr    (r_state == STORE),
        .i_en     (r_mac_vld),
        .i_coef   (RAM_coefs_dataout),
        .i_x      (r_x),
        .i_nquant (r_nquant),
        .o_y      (w_y)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_wp        <= '0;
            r_tap       <= '0;
            r_ch        <= '0;
            r_nquant    <= '0;
            r_addr      <= '0;
            r_base      <= '0;
            r_x         <= '0;
            r_mac_vld   <= 1'b0;
            r_res       <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            for (int c = 0; c < NCH; c++)
                for (int t = 0; t < NTAPS; t++)
                    r_dl[c][t] <= '0;
        end else begin
            r_out_valid <= 1'b0;
            // Sample is delayed one cycle to line up with the RAM read latency.
            r_mac_vld   <= (r_state == MAC);
            r_x         <= r_dl[r_ch][w_rd];
            if (data_en && !w_accept) r_overrun <= 1'b1;
            case (r_state)
                IDLE, OUT: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                    if (data_en) begin
                        for (int c = 0; c < NCH; c++)
                            r_dl[c][r_wp] <= data_in[c*DW +: DW];
                        r_nquant <= Nquant;
                        r_busy   <= 1'b1;
                        if (bypass) begin
                            r_data_out  <= data_in;
                            r_out_valid <= 1'b1;
                            r_wp        <= r_wp + 1'b1;
                            r_state     <= OUT;
                        end else begin
                            r_base  <= w_base;
                            r_addr  <= w_base;
                            r_tap   <= '0;
                            r_ch    <= '0;
                            r_state <= MAC;
                        end
                    end
                end
                MAC: begin
                    if (r_tap == LW'(NTAPS - 1)) begin
                        r_state <= DRAIN;
                    end else begin
                        r_tap  <= r_tap + 1'b1;
                        r_addr <= r_addr + 1'b1;
                    end
                end
                DRAIN: r_state <= STORE;
                STORE: begin
                    r_res  <= w_res;
                    r_tap  <= '0;
                    if (r_ch == CHW'(NCH - 1)) begin
                        r_data_out  <= w_res;
                        r_out_valid <= 1'b1;
                        r_wp        <= r_wp + 1'b1;
                        r_state     <= OUT;
                    end else begin
                        r_addr  <= r_base;
                        r_ch    <= r_ch + 1'b1;
                        r_state <= MAC;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
